if_id_skid_reg: RTL and testbench



---
 rtl/if_id_pkg.sv | 30 +++
 rtl/if_id_skid_reg_sat_counter.sv | 27 ++
 rtl/if_id_skid_reg.sv | 147 ++++++++++++++
 tb/tb_if_id_skid_reg.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// Shared types for the fetch/decode boundary register.
// Optional performance counters are enabled with IF_ID_PERF_EN.
package if_id_pkg;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } if_id_state_e;

    // Default widths of the fetched bundle.
    localparam int ENTRY_PC_W   = 5;
    localparam int ENTRY_INST_W = 32;

    // addi x0,x0,0 : the canonical RV32 bubble.
    localparam logic [31:0] NOP_RV32 = 32'h0000_0013;

    // Fetched bundle at default widths.
    typedef struct packed {
        logic [ENTRY_PC_W-1:0]   pc;
        logic [ENTRY_INST_W-1:0] inst;
    } if_id_entry_t;

    // True when the given state holds at least one entry.
    function automatic logic state_has_entry(if_id_state_e s);
        return s != EMPTY;
    endfunction

endpackage

// File: rtl/if_id_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Used by if_id_skid_reg when IF_ID_PERF_EN is defined.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic         at_max;

    assign at_max = &count_q;
    assign count  = count_q;

    // Count up on inc, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && !at_max) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a two-entry skid buffer and flush.
// IF_ID_PERF_EN adds saturating stall and flush counters.
module if_id_skid_reg
    import if_id_pkg::*;
#(
    parameter int                PC_W     = ENTRY_PC_W,
    parameter int                INST_W   = ENTRY_INST_W,
    parameter logic [INST_W-1:0] NOP_INST = NOP_RV32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst
`ifdef IF_ID_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    // Bundle sized to this instance's parameters.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    if_id_state_e state_q;
    if_id_state_e state_d;

    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;

    logic accept;
    logic load_main;
    logic load_skid;
    logic pop_skid;

    assign in_entry.pc   = if_pc;
    assign in_entry.inst = if_inst;

    // if_ready depends only on registered state.
    assign if_ready = (state_q != SKID);
    assign accept   = if_valid && if_ready;

    assign id_valid = state_has_entry(state_q);
    assign id_pc    = id_valid ? main_q.pc : '0;
    assign id_inst  = id_valid ? main_q.inst : NOP_INST;

    // Next-state and entry-move decisions; flush beats everything.
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = FULL;
                        load_main = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && id_ready) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = SKID;
                        load_skid = 1'b1;
                    end else if (id_ready) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (id_ready) begin
                        state_d  = FULL;
                        pop_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main entry: new fetch, or promoted skid entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
        end else if (load_main) begin
            main_q <= in_entry;
        end else if (pop_skid) begin
            main_q <= skid_q;
        end
    end

    // Skid entry catches the fetch that arrives during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= in_entry;
        end
    end

`ifdef IF_ID_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = id_valid && !id_ready;
    assign flush_inc = flush && id_valid;

    sat_counter #(.W(16)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(16)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg.
// Counter checks compile in when IF_ID_PERF_EN is defined.
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [4:0]  if_pc;
    logic [31:0] if_inst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_pc;
    logic [31:0] id_inst;
`ifdef IF_ID_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    if_id_skid_reg dut (
        .clk      (clk),
        .reset    (reset),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .flush    (flush),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_pc    (id_pc),
        .id_inst  (id_inst)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic v, input logic [4:0] pc,
                         input logic [31:0] inst);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        id_ready = 1'b0;
        fetch(1'b1, 5'd3, 32'hDEADBEEF);

        // Reset with a valid fetch pending.
        tick();
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_inst", id_inst, NOP);
        check("rst_pc", {27'd0, id_pc}, 32'd0);
        check("rst_ready", {31'd0, if_ready}, 32'd1);
        tick();
        check("rst2_valid", {31'd0, id_valid}, 32'd0);
        check("rst2_inst", id_inst, NOP);
        reset = 1'b0;
        fetch(1'b0, 5'd0, 32'h0);
        tick();
        check("post_rst_valid", {31'd0, id_valid}, 32'd0);

        // Streaming at full rate.
        id_ready = 1'b1;
        fetch(1'b1, 5'd0, 32'h11);
        tick();
        check("s0_pc", {27'd0, id_pc}, 32'd0);
        check("s0_inst", id_inst, 32'h11);
        check("s0_valid", {31'd0, id_valid}, 32'd1);
        fetch(1'b1, 5'd4, 32'h22);
        tick();
        check("s1_inst", id_inst, 32'h22);
        check("s1_ready", {31'd0, if_ready}, 32'd1);
        fetch(1'b1, 5'd8, 32'h33);
        tick();
        check("s2_pc", {27'd0, id_pc}, 32'd8);
        fetch(1'b1, 5'd12, 32'h44);
        tick();
        check("s3_pc", {27'd0, id_pc}, 32'd12);
        check("s3_inst", id_inst, 32'h44);
        check("s3_ready", {31'd0, if_ready}, 32'd1);
        fetch(1'b0, 5'd0, 32'h0);
        tick();
        check("drain_valid", {31'd0, id_valid}, 32'd0);
        check("drain_inst", id_inst, NOP);

        // Stall fills main then skid.
        id_ready = 1'b0;
        fetch(1'b1, 5'd4, 32'hA4);
        tick();
        check("st0_pc", {27'd0, id_pc}, 32'd4);
        check("st0_ready", {31'd0, if_ready}, 32'd1);
        fetch(1'b1, 5'd8, 32'hA8);
        tick();
        check("st1_ready", {31'd0, if_ready}, 32'd0);
        check("st1_pc", {27'd0, id_pc}, 32'd4);
        fetch(1'b1, 5'd9, 32'hA9);
        tick();
        check("st2_hold_pc", {27'd0, id_pc}, 32'd4);
        check("st2_hold_inst", id_inst, 32'hA4);
        check("st2_ready", {31'd0, if_ready}, 32'd0);
        fetch(1'b0, 5'd0, 32'h0);
        id_ready = 1'b1;
        #1;
        check("rel_first_pc", {27'd0, id_pc}, 32'd4);
        tick();
        check("rel_second_pc", {27'd0, id_pc}, 32'd8);
        check("rel_second_inst", id_inst, 32'hA8);
        check("rel_ready", {31'd0, if_ready}, 32'd1);
        tick();
        check("rel_empty", {31'd0, id_valid}, 32'd0);

        // Flush from SKID discards the incoming fetch.
        id_ready = 1'b0;
        fetch(1'b1, 5'd1, 32'hB1);
        tick();
        fetch(1'b1, 5'd2, 32'hB2);
        tick();
        check("fl_pre_ready", {31'd0, if_ready}, 32'd0);
        flush = 1'b1;
        fetch(1'b1, 5'd16, 32'hB16);
        tick();
        check("fl_valid", {31'd0, id_valid}, 32'd0);
        check("fl_inst", id_inst, NOP);
        check("fl_ready", {31'd0, if_ready}, 32'd1);
        flush = 1'b0;
        fetch(1'b0, 5'd0, 32'h0);
        id_ready = 1'b1;
        tick();
        check("fl_after_valid", {31'd0, id_valid}, 32'd0);
        check("fl_after_pc", {27'd0, id_pc}, 32'd0);

        // Flush held over several cycles with fetch offered.
        flush = 1'b1;
        fetch(1'b1, 5'd5, 32'hC5);
        tick();
        check("flh0_valid", {31'd0, id_valid}, 32'd0);
        tick();
        check("flh1_valid", {31'd0, id_valid}, 32'd0);
        check("flh1_ready", {31'd0, if_ready}, 32'd1);
        flush = 1'b0;
        fetch(1'b0, 5'd0, 32'h0);

        // Reset while SKID and stalled.
        id_ready = 1'b0;
        fetch(1'b1, 5'd6, 32'hD6);
        tick();
        fetch(1'b1, 5'd7, 32'hD7);
        tick();
        check("rs_pre_pc", {27'd0, id_pc}, 32'd6);
        reset = 1'b1;
        fetch(1'b0, 5'd0, 32'h0);
        tick();
        check("rs_valid", {31'd0, id_valid}, 32'd0);
        check("rs_inst", id_inst, NOP);
        check("rs_ready", {31'd0, if_ready}, 32'd1);
        reset = 1'b0;
        id_ready = 1'b1;
        tick();
        check("rs_lost", {31'd0, id_valid}, 32'd0);

`ifdef IF_ID_PERF_EN
        check("pc_rst_stall", {16'd0, stall_cnt}, 32'd0);
        check("pc_rst_flush", {16'd0, flush_cnt}, 32'd0);
        id_ready = 1'b0;
        fetch(1'b1, 5'd3, 32'hE3);
        tick();
        fetch(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        id_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("pc_stall10", {16'd0, stall_cnt}, 32'd10);
        check("pc_flush1", {16'd0, flush_cnt}, 32'd1);
        force dut.u_stall_cnt.count_q = 16'hFFFE;
        #1;
        release dut.u_stall_cnt.count_q;
        id_ready = 1'b0;
        fetch(1'b1, 5'd4, 32'hE4);
        tick();
        fetch(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        check("pc_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        check("pc_flush_keep", {16'd0, flush_cnt}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
